// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : counter_pkg
//  Purpose  : Shared constants for the counter family (default width and
//             wrap-mode selectors used by the AUTO_RELOAD parameter).
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package counter_pkg;

    localparam int DEFAULT_WIDTH = 3;

    // Behaviour when an enabled decrement happens at zero.
    localparam bit WRAP_ONES   = 1'b0;  // wrap to all ones
    localparam bit WRAP_RELOAD = 1'b1;  // restart from the stored reload value

endpackage : counter_pkg
`default_nettype wire

// File: rtl/dff_ar.sv
`default_nettype none
// ============================================================================
//  Module   : dff_ar
//  Purpose  : Single-bit D flip-flop with asynchronous active-high reset and
//             a parameterised reset value.
//  Ports    : clk  - rising-edge clock
//             rst  - asynchronous active-high reset
//             i_d  - data input
//             o_q  - registered output
//  Revision : 1.0  initial release
// ============================================================================
module dff_ar #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : dff_ar
`default_nettype wire

// File: rtl/down_counter_ld.sv
`default_nettype none
// ============================================================================
//  Module   : down_counter_ld
//  Purpose  : Loadable WIDTH-bit binary down counter with a registered
//             one-cycle terminal-count pulse. On an enabled decrement from
//             zero it either wraps to all ones or restarts from the last
//             loaded value (AUTO_RELOAD).
//  Ports    : clk      - rising-edge clock
//             reset    - asynchronous active-high reset
//             load     - load request (priority over en)
//             load_val - value written to Count and the reload register
//             en       - count enable
//             Count    - registered counter value
//             zero     - combinational Count == 0
//             tc       - registered terminal-count pulse
//  Revision : 1.0  initial release
// ============================================================================
module down_counter_ld
    import counter_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL   = '1,
    parameter bit               AUTO_RELOAD = WRAP_ONES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] Count,
    output logic             zero,
    output logic             tc
);

    typedef logic [WIDTH-1:0] count_t;

    count_t r_count;
    count_t r_reload;
    logic   r_tc;

    count_t w_borrow;
    count_t w_count_d;
    count_t w_reload_d;
    logic   w_zero;
    logic   w_wrap;
    logic   w_tc_d;

    // Ripple-borrow chain: bit i toggles when enabled and every lower bit
    // is zero. At Count == 0 every bit toggles, giving the natural wrap to
    // all ones; en low leaves the chain all zero so Count holds.
    assign w_borrow[0] = en;

    for (genvar i = 1; i < WIDTH; i++) begin : g_borrow
        assign w_borrow[i] = w_borrow[i-1] & ~r_count[i-1];
    end

    assign w_zero = (r_count == '0);
    assign w_wrap = en & w_zero;

    always_comb begin
        w_count_d = r_count ^ w_borrow;
        if (load) begin
            w_count_d = load_val;
        end else if (w_wrap && (AUTO_RELOAD == WRAP_RELOAD)) begin
            w_count_d = r_reload;
        end
    end

    assign w_reload_d = load ? load_val : r_reload;

    // A load in the same cycle as a wrap suppresses the pulse.
    assign w_tc_d = ~load & w_wrap;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bits
        dff_ar #(
            .RESET_VAL (RESET_VAL[i])
        ) u_count (
            .clk (clk),
            .rst (reset),
            .i_d (w_count_d[i]),
            .o_q (r_count[i])
        );

        dff_ar #(
            .RESET_VAL (RESET_VAL[i])
        ) u_reload (
            .clk (clk),
            .rst (reset),
            .i_d (w_reload_d[i]),
            .o_q (r_reload[i])
        );
    end

    dff_ar #(
        .RESET_VAL (1'b0)
    ) u_tc (
        .clk (clk),
        .rst (reset),
        .i_d (w_tc_d),
        .o_q (r_tc)
    );

    assign Count = r_count;
    assign zero  = w_zero;
    assign tc    = r_tc;

endmodule : down_counter_ld
`default_nettype wire

// File: tb/tb_down_counter_ld.sv
`default_nettype none
// ============================================================================
//  Module   : tb_down_counter_ld
//  Purpose  : Directed self-checking bench for down_counter_ld. Two instances
//             share stimulus: u_wrap (AUTO_RELOAD=0) and u_rld (AUTO_RELOAD=1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_down_counter_ld;

    logic       clk;
    logic       reset;
    logic       load;
    logic [2:0] load_val;
    logic       en;

    logic [2:0] cnt_w, cnt_r;
    logic       zero_w, zero_r;
    logic       tc_w, tc_r;

    int errors = 0;
    int checks = 0;

    down_counter_ld #(.WIDTH(3), .RESET_VAL(3'b111), .AUTO_RELOAD(1'b0)) u_wrap (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .Count    (cnt_w),
        .zero     (zero_w),
        .tc       (tc_w)
    );

    down_counter_ld #(.WIDTH(3), .RESET_VAL(3'b111), .AUTO_RELOAD(1'b1)) u_rld (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .Count    (cnt_r),
        .zero     (zero_r),
        .tc       (tc_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; load_val = 3'd0; en = 1'b0;
        #2;
        checks++;
        if (cnt_w !== 3'd7 || cnt_r !== 3'd7) begin
            errors++; $display("FAIL reset_count: got %0d/%0d want 7", cnt_w, cnt_r);
        end
        checks++;
        if (tc_w !== 1'b0 || tc_r !== 1'b0 || zero_w !== 1'b0 || zero_r !== 1'b0) begin
            errors++; $display("FAIL reset_flags: tc=%b/%b zero=%b/%b want 0", tc_w, tc_r, zero_w, zero_r);
        end
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (cnt_w !== 3'd7) begin
            errors++; $display("FAIL reset_hold: got %0d want 7", cnt_w);
        end
    endtask

    task automatic test_reset_mid_count();
        load = 1'b1; load_val = 3'd5; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        tick();
        checks++;
        if (cnt_w !== 3'd3) begin
            errors++; $display("FAIL midcount_pre: got %0d want 3", cnt_w);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (cnt_w !== 3'd7 || tc_w !== 1'b0) begin
            errors++; $display("FAIL midcount_async: count=%0d tc=%b want 7/0", cnt_w, tc_w);
        end
        #1;
        reset = 1'b0; en = 1'b0;
        tick();
    endtask

    task automatic test_freerun_wrap();
        logic [2:0] exp_seq [10];
        exp_seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};
        en = 1'b0; load = 1'b0;
        do_reset();
        en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (cnt_w !== exp_seq[k] || tc_w !== (k == 8) || zero_w !== (exp_seq[k] == 3'd0)) begin
                errors++;
                $display("FAIL freerun[%0d]: count=%0d tc=%b zero=%b want %0d/%b/%b",
                         k, cnt_w, tc_w, zero_w, exp_seq[k], (k == 8), (exp_seq[k] == 3'd0));
            end
            if (k < 9) tick();
        end
        en = 1'b0;
    endtask

    task automatic test_load_priority();
        load = 1'b1; load_val = 3'd0; en = 1'b0;
        tick();
        checks++;
        if (cnt_w !== 3'd0 || zero_w !== 1'b1) begin
            errors++; $display("FAIL prio_setup: count=%0d zero=%b want 0/1", cnt_w, zero_w);
        end
        load = 1'b1; load_val = 3'd4; en = 1'b1;
        tick();
        checks++;
        if (cnt_w !== 3'd4 || cnt_r !== 3'd4 || tc_w !== 1'b0 || tc_r !== 1'b0) begin
            errors++; $display("FAIL load_priority: count=%0d/%0d tc=%b/%b want 4/4 0/0", cnt_w, cnt_r, tc_w, tc_r);
        end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_auto_reload();
        logic [2:0] exp_seq [6];
        logic       exp_tc  [6];
        exp_seq = '{3'd2, 3'd1, 3'd0, 3'd2, 3'd1, 3'd0};
        exp_tc  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        load = 1'b1; load_val = 3'd2; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (cnt_r !== exp_seq[k] || tc_r !== exp_tc[k]) begin
                errors++;
                $display("FAIL autoreload[%0d]: count=%0d tc=%b want %0d/%b", k, cnt_r, tc_r, exp_seq[k], exp_tc[k]);
            end
            tick();
        end
        // Seventh sample: count back at 2 with the second pulse.
        checks++;
        if (cnt_r !== 3'd2 || tc_r !== 1'b1) begin
            errors++; $display("FAIL autoreload_period: count=%0d tc=%b want 2/1", cnt_r, tc_r);
        end
        en = 1'b0;
    endtask

    task automatic test_hold();
        load = 1'b1; load_val = 3'd6; en = 1'b0;
        tick();
        load = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (cnt_w !== 3'd6 || cnt_r !== 3'd6 || tc_w !== 1'b0 || zero_w !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: count=%0d/%0d tc=%b zero=%b want 6/6 0 0", k, cnt_w, cnt_r, tc_w, zero_w);
            end
        end
    endtask

    task automatic test_zero_load();
        load = 1'b1; load_val = 3'd0; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1;
        checks++;
        if (cnt_w !== 3'd0 || zero_w !== 1'b1 || cnt_r !== 3'd0 || zero_r !== 1'b1) begin
            errors++; $display("FAIL zeroload_loaded: count=%0d/%0d zero=%b/%b want 0/0 1/1", cnt_w, cnt_r, zero_w, zero_r);
        end
        tick();
        checks++;
        if (cnt_w !== 3'd7 || tc_w !== 1'b1 || zero_w !== 1'b0) begin
            errors++; $display("FAIL zeroload_wrap: count=%0d tc=%b zero=%b want 7/1/0", cnt_w, tc_w, zero_w);
        end
        checks++;
        if (cnt_r !== 3'd0 || tc_r !== 1'b1 || zero_r !== 1'b1) begin
            errors++; $display("FAIL zeroload_rld1: count=%0d tc=%b zero=%b want 0/1/1", cnt_r, tc_r, zero_r);
        end
        tick();
        checks++;
        if (cnt_w !== 3'd6 || tc_w !== 1'b0) begin
            errors++; $display("FAIL zeroload_single_tc: count=%0d tc=%b want 6/0", cnt_w, tc_w);
        end
        checks++;
        if (cnt_r !== 3'd0 || tc_r !== 1'b1) begin
            errors++; $display("FAIL zeroload_rld2: count=%0d tc=%b want 0/1", cnt_r, tc_r);
        end
        tick();
        checks++;
        if (cnt_r !== 3'd0 || tc_r !== 1'b1) begin
            errors++; $display("FAIL zeroload_rld3: count=%0d tc=%b want 0/1", cnt_r, tc_r);
        end
        en = 1'b0;
        tick();
        checks++;
        if (cnt_r !== 3'd0 || tc_r !== 1'b0) begin
            errors++; $display("FAIL zeroload_stop: count=%0d tc=%b want 0/0", cnt_r, tc_r);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_count();
        test_freerun_wrap();
        test_load_priority();
        test_auto_reload();
        test_hold();
        test_zero_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_down_counter_ld
`default_nettype wire
